data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_if.sv | 31 +++
 rtl/data_mem_ctrl.sv | 177 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl_if
// Request/response bundle between a load/store unit and data_mem_ctrl.
//   Request : iReq_Valid, oReq_Ready, iReq_WrEn, iFunct3[2:0], iAddr[31:0],
//             iWrData[31:0]
//   Response: oRsp_Valid, iRsp_Ready, oRsp_RdData[31:0], oRsp_Err
// Signal names keep the memory block's port view: i* is driven by the
// requester (master), o* is driven by the memory controller (slave).
// -----------------------------------------------------------------------------
interface data_mem_ctrl_if;
  logic        iReq_Valid;
  logic        oReq_Ready;
  logic        iReq_WrEn;
  logic [2:0]  iFunct3;
  logic [31:0] iAddr;
  logic [31:0] iWrData;
  logic        oRsp_Valid;
  logic        iRsp_Ready;
  logic [31:0] oRsp_RdData;
  logic        oRsp_Err;

  modport master (
    output iReq_Valid, iReq_WrEn, iFunct3, iAddr, iWrData, iRsp_Ready,
    input  oReq_Ready, oRsp_Valid, oRsp_RdData, oRsp_Err
  );

  modport slave (
    input  iReq_Valid, iReq_WrEn, iFunct3, iAddr, iWrData, iRsp_Ready,
    output oReq_Ready, oRsp_Valid, oRsp_RdData, oRsp_Err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
// Byte-addressable RV32I data memory of DEPTH 32-bit words behind a
// valid/ready request and response handshake. Each transaction walks
// IDLE -> ACCESS -> RESP; stores update only the addressed byte lanes, loads
// return the lane(s) already sign- or zero-extended.
// Ports:
//   iClk  - sole clock, rising edge
//   iRst  - synchronous active-high reset (control and response only; the
//           memory array keeps its contents)
//   bus   - data_mem_ctrl_if.slave (request and response channels)
// Parameters:
//   DEPTH     - number of words, power of two, >= 4
//   INIT_BASE - word i powers up holding INIT_BASE + i
// Build option:
//   DATA_MEM_MISALIGN_TRAP_EN - when defined, misaligned halfword/word
//   accesses fault; otherwise the unused low address bits are ignored.
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int unsigned DEPTH     = 64,
  parameter logic [31:0] INIT_BASE = 32'h1234_8000
) (
  input logic            iClk,
  input logic            iRst,
  data_mem_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic        reqReady;
  logic        rspValid;
  logic        rspErr;
  logic [31:0] rspRdData;

  logic        wrEn_p0;
  logic [2:0]  funct3_p0;
  logic [31:0] addr_p0;
  logic [31:0] wrData_p0;

  logic          accept;
  logic [AW-1:0] wordIdx;
  logic [1:0]    lane;
  logic          outOfRange;
  logic          illegalOp;
  logic          misalign;
  logic          fault;
  logic          wrStrobe;
  logic [3:0]    wrMask;
  logic [31:0]   wrLanes;
  logic [31:0]   memRd [DEPTH];

  // Lanes touched by an access of size funct3[1:0] at byte offset ln.
  function automatic logic [3:0] laneMask(input logic [1:0] sz, input logic [1:0] ln);
    case (sz)
      2'b00:   laneMask = 4'b0001 << ln;
      2'b01:   laneMask = ln[1] ? 4'b1100 : 4'b0011;
      default: laneMask = 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so the mask alone picks the target.
  function automatic logic [31:0] laneData(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   laneData = {4{wd[7:0]}};
      2'b01:   laneData = {2{wd[15:0]}};
      default: laneData = wd;
    endcase
  endfunction

  // Lane extraction plus sign/zero extension of a load result.
  function automatic logic [31:0] loadExtend(input logic [2:0] f3, input logic [1:0] ln,
                                             input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{ln, 3'b000} +: 8];
    h = ln[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  loadExtend = 32'(b);
      3'b001:  loadExtend = 32'(h);
      3'b100:  loadExtend = {24'd0, b};
      3'b101:  loadExtend = {16'd0, h};
      default: loadExtend = word;
    endcase
  endfunction

  assign accept = (state == IDLE) && bus.iReq_Valid && reqReady;

  // Request capture: the transaction runs only on these copies.
  always_ff @(posedge iClk) begin
    if (accept) begin
      wrEn_p0   <= bus.iReq_WrEn;
      funct3_p0 <= bus.iFunct3;
      addr_p0   <= bus.iAddr;
      wrData_p0 <= bus.iWrData;
    end
  end

  assign wordIdx    = addr_p0[AW+1:2];
  assign lane       = addr_p0[1:0];
  assign outOfRange = |addr_p0[31:AW+2];
  assign illegalOp  = (funct3_p0 == 3'b011) || (funct3_p0[2:1] == 2'b11) ||
                      (wrEn_p0 && funct3_p0[2]);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign misalign   = ((funct3_p0[1:0] == 2'b01) && lane[0]) ||
                      ((funct3_p0[1:0] == 2'b10) && (lane != 2'b00));
`else
  assign misalign   = 1'b0;
`endif
  assign fault      = outOfRange || illegalOp || misalign;

  // Reset wins over a store sitting in ACCESS.
  assign wrStrobe = (state == ACCESS) && wrEn_p0 && !fault && !iRst;
  assign wrMask   = laneMask(funct3_p0[1:0], lane);
  assign wrLanes  = laneData(funct3_p0[1:0], wrData_p0);

  // Memory array: one register per word so each can carry its power-up
  // pattern; reset never touches it.
  for (genvar i = 0; i < DEPTH; i++) begin : gWord
    logic [31:0] word = INIT_BASE + 32'(i);
    always_ff @(posedge iClk) begin
      if (wrStrobe && (wordIdx == AW'(i))) begin
        for (int b = 0; b < 4; b++) begin
          if (wrMask[b]) word[8*b +: 8] <= wrLanes[8*b +: 8];
        end
      end
    end
    assign memRd[i] = word;
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state     <= IDLE;
      reqReady  <= 1'b1;
      rspValid  <= 1'b0;
      rspRdData <= '0;
      rspErr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= ACCESS;
            reqReady <= 1'b0;
          end
        end
        ACCESS: begin
          state     <= RESP;
          rspValid  <= 1'b1;
          rspErr    <= fault;
          rspRdData <= (fault || wrEn_p0) ? '0
                                          : loadExtend(funct3_p0, lane, memRd[wordIdx]);
        end
        RESP: begin
          if (bus.iRsp_Ready) begin
            state    <= IDLE;
            rspValid <= 1'b0;
            reqReady <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          reqReady <= 1'b1;
          rspValid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.oReq_Ready  = reqReady;
  assign bus.oRsp_Valid  = rspValid;
  assign bus.oRsp_RdData = rspRdData;
  assign bus.oRsp_Err    = rspErr;

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nCmp = 0;
  int   nErr = 0;

  data_mem_ctrl_if bus ();

  data_mem_ctrl #(.DEPTH(64), .INIT_BASE(32'h1234_8000)) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Issue one transaction and collect its response. lat counts clock edges
  // from the acceptance edge (inclusive) to the first sample with valid high.
  task automatic doTxn(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat);
    int n;
    @(negedge clk);
    bus.iReq_Valid = 1'b1;
    bus.iReq_WrEn  = wr;
    bus.iFunct3    = f3;
    bus.iAddr      = a;
    bus.iWrData    = wd;
    n = 0;
    while (!bus.oReq_Ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.iReq_Valid = 1'b0;
    lat = 1;
    while (!bus.oRsp_Valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = bus.oRsp_RdData;
    er = bus.oRsp_Err;
    bus.iRsp_Ready = 1'b1;
    @(negedge clk);
    bus.iRsp_Ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    nCmp++; if (bus.oReq_Ready !== 1'b1) begin nErr++; $display("FAIL rst_ready got=%b exp=1", bus.oReq_Ready); end
    nCmp++; if (bus.oRsp_Valid !== 1'b0) begin nErr++; $display("FAIL rst_valid got=%b exp=0", bus.oRsp_Valid); end
    nCmp++; if (bus.oRsp_RdData !== 32'h0) begin nErr++; $display("FAIL rst_rddata got=%h exp=0", bus.oRsp_RdData); end
    nCmp++; if (bus.oRsp_Err !== 1'b0) begin nErr++; $display("FAIL rst_err got=%b exp=0", bus.oRsp_Err); end
    rst = 1'b0;
    @(negedge clk);
    nCmp++; if (bus.oReq_Ready !== 1'b1) begin nErr++; $display("FAIL rst_release_ready got=%b exp=1", bus.oReq_Ready); end
  endtask

  task automatic test_load_word();
    logic [31:0] rd; logic er; int lat;
    doTxn(1'b0, 3'b010, 32'h08, 32'h0, rd, er, lat);
    nCmp++; if (rd !== 32'h1234_8002) begin nErr++; $display("FAIL lw08_data got=%h exp=12348002", rd); end
    nCmp++; if (er !== 1'b0) begin nErr++; $display("FAIL lw08_err got=%b exp=0", er); end
    nCmp++; if (lat !== 2) begin nErr++; $display("FAIL lw08_latency got=%0d exp=2", lat); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    doTxn(1'b1, 3'b000, 32'h05, 32'h0000_00AB, rd, er, lat);
    nCmp++; if (rd !== 32'h0 || er !== 1'b0) begin nErr++; $display("FAIL sb05_rsp got=%h/%b exp=0/0", rd, er); end
    doTxn(1'b0, 3'b010, 32'h04, 32'h0, rd, er, lat);
    nCmp++; if (rd !== 32'h1234_AB01) begin nErr++; $display("FAIL sb_lw04 got=%h exp=1234ab01", rd); end
    doTxn(1'b0, 3'b000, 32'h05, 32'h0, rd, er, lat);
    nCmp++; if (rd !== 32'hFFFF_FFAB) begin nErr++; $display("FAIL lb05 got=%h exp=ffffffab", rd); end
    doTxn(1'b0, 3'b100, 32'h05, 32'h0, rd, er, lat);
    nCmp++; if (rd !== 32'h0000_00AB) begin nErr++; $display("FAIL lbu05 got=%h exp=000000ab", rd); end
    doTxn(1'b0, 3'b100, 32'h04, 32'h0, rd, er, lat);
    nCmp++; if (rd !== 32'h0000_0001) begin nErr++; $display("FAIL lbu04 got=%h exp=00000001", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    doTxn(1'b1, 3'b001, 32'h0E, 32'hFFFF_8001, rd, er, lat);
    nCmp++; if (er !== 1'b0) begin nErr++; $display("FAIL sh0e_err got=%b exp=0", er); end
    doTxn(1'b0, 3'b001, 32'h0E, 32'h0, rd, er, lat);
    nCmp++; if (rd !== 32'hFFFF_8001) begin nErr++; $display("FAIL lh0e got=%h exp=ffff8001", rd); end
    doTxn(1'b0, 3'b101, 32'h0E, 32'h0, rd, er, lat);
    nCmp++; if (rd !== 32'h0000_8001) begin nErr++; $display("FAIL lhu0e got=%h exp=00008001", rd); end
    // word 3 powers up as 0x1234_8003; only its upper half was replaced
    doTxn(1'b0, 3'b010, 32'h0C, 32'h0, rd, er, lat);
    nCmp++; if (rd !== 32'h8001_8003) begin nErr++; $display("FAIL sh_lw0c got=%h exp=80018003", rd); end
    doTxn(1'b0, 3'b001, 32'h0F, 32'h0, rd, er, lat);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    nCmp++; if (rd !== 32'h0 || er !== 1'b1) begin nErr++; $display("FAIL lh0f_misalign got=%h/%b exp=0/1", rd, er); end
`else
    nCmp++; if (rd !== 32'hFFFF_8001 || er !== 1'b0) begin nErr++; $display("FAIL lh0f got=%h/%b exp=ffff8001/0", rd, er); end
`endif
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    doTxn(1'b0, 3'b010, 32'h100, 32'h0, rd, er, lat);
    nCmp++; if (rd !== 32'h0 || er !== 1'b1) begin nErr++; $display("FAIL lw100 got=%h/%b exp=0/1", rd, er); end
    doTxn(1'b1, 3'b010, 32'h100, 32'hFFFF_FFFF, rd, er, lat);
    nCmp++; if (er !== 1'b1) begin nErr++; $display("FAIL sw100_err got=%b exp=1", er); end
    doTxn(1'b1, 3'b100, 32'h00, 32'hFFFF_FFFF, rd, er, lat);
    nCmp++; if (er !== 1'b1) begin nErr++; $display("FAIL store_bu_err got=%b exp=1", er); end
    doTxn(1'b0, 3'b011, 32'h00, 32'h0, rd, er, lat);
    nCmp++; if (rd !== 32'h0 || er !== 1'b1) begin nErr++; $display("FAIL f3_011 got=%h/%b exp=0/1", rd, er); end
    doTxn(1'b0, 3'b110, 32'h00, 32'h0, rd, er, lat);
    nCmp++; if (er !== 1'b1) begin nErr++; $display("FAIL f3_110 got=%b exp=1", er); end
    // address 0x100 aliases word 0 in its index bits; it must be untouched
    doTxn(1'b0, 3'b010, 32'h00, 32'h0, rd, er, lat);
    nCmp++; if (rd !== 32'h1234_8000 || er !== 1'b0) begin nErr++; $display("FAIL word0_intact got=%h/%b exp=12348000/0", rd, er); end
  endtask

  task automatic test_hold();
    int n;
    @(negedge clk);
    bus.iReq_Valid = 1'b1;
    bus.iReq_WrEn  = 1'b0;
    bus.iFunct3    = 3'b010;
    bus.iAddr      = 32'h08;
    bus.iWrData    = 32'h0;
    @(negedge clk);
    // changes after acceptance must not leak into the transaction
    bus.iReq_WrEn = 1'b1;
    bus.iFunct3   = 3'b111;
    bus.iAddr     = 32'h100;
    n = 0;
    while (!bus.oRsp_Valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      bus.iReq_Valid = k[0];
      @(negedge clk);
      nCmp++;
      if (bus.oRsp_Valid !== 1'b1 || bus.oRsp_RdData !== 32'h1234_8002 ||
          bus.oRsp_Err !== 1'b0 || bus.oReq_Ready !== 1'b0) begin
        nErr++;
        $display("FAIL hold_cycle%0d got v=%b d=%h e=%b r=%b exp v=1 d=12348002 e=0 r=0",
                 k, bus.oRsp_Valid, bus.oRsp_RdData, bus.oRsp_Err, bus.oReq_Ready);
      end
    end
    bus.iReq_Valid = 1'b0;
    bus.iRsp_Ready = 1'b1;
    @(negedge clk);
    bus.iRsp_Ready = 1'b0;
    nCmp++; if (bus.oRsp_Valid !== 1'b0 || bus.oReq_Ready !== 1'b1) begin nErr++; $display("FAIL hold_release got v=%b r=%b exp v=0 r=1", bus.oRsp_Valid, bus.oReq_Ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] vals [3] = '{32'h55AA_1234, 32'h0000_0000, 32'hCAFE_F00D};
    for (int k = 0; k < 3; k++) begin
      doTxn(1'b1, 3'b010, 32'h20, vals[k], rd, er, lat);
      doTxn(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
      nCmp++; if (rd !== vals[k]) begin nErr++; $display("FAIL b2b_%0d got=%h exp=%h", k, rd, vals[k]); end
    end
  endtask

  task automatic test_reset_in_access();
    logic [31:0] rd; logic er; int lat;
    @(negedge clk);
    bus.iReq_Valid = 1'b1;
    bus.iReq_WrEn  = 1'b1;
    bus.iFunct3    = 3'b010;
    bus.iAddr      = 32'h10;
    bus.iWrData    = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.iReq_Valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    nCmp++; if (bus.oRsp_Valid !== 1'b0 || bus.oReq_Ready !== 1'b1) begin nErr++; $display("FAIL rst_access_state got v=%b r=%b exp v=0 r=1", bus.oRsp_Valid, bus.oReq_Ready); end
    doTxn(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    nCmp++; if (rd !== 32'h1234_8004 || er !== 1'b0) begin nErr++; $display("FAIL rst_access_word4 got=%h/%b exp=12348004/0", rd, er); end
    doTxn(1'b0, 3'b010, 32'h11, 32'h0, rd, er, lat);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    nCmp++; if (rd !== 32'h0 || er !== 1'b1) begin nErr++; $display("FAIL lw11_misalign got=%h/%b exp=0/1", rd, er); end
`else
    nCmp++; if (rd !== 32'h1234_8004 || er !== 1'b0) begin nErr++; $display("FAIL lw11 got=%h/%b exp=12348004/0", rd, er); end
`endif
  endtask

  initial begin
    bus.iReq_Valid = 1'b0;
    bus.iReq_WrEn  = 1'b0;
    bus.iFunct3    = 3'b000;
    bus.iAddr      = 32'h0;
    bus.iWrData    = 32'h0;
    bus.iRsp_Ready = 1'b0;
    test_reset();
    test_load_word();
    test_byte();
    test_half();
    test_errors();
    test_hold();
    test_back_to_back();
    test_reset_in_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
